// File: rtl/quadrature_decoder_if.sv
// Signal bundle between a quadrature pin source and the decoder.
// Only the A/B pins are asynchronous; everything else lives in the decoder clock domain.
interface quadrature_decoder_if #(
  parameter int CNT_WIDTH = 16,
  parameter int SPD_WIDTH = 16
);
  logic                 A;
  logic                 B;
  logic                 enable;
  logic                 clear_pos;
  logic                 clear_err;
  logic [CNT_WIDTH-1:0] position;
  logic                 dir;
  logic                 step_pulse;
  logic [SPD_WIDTH-1:0] speed;
  logic                 speed_valid;
  logic                 err;

  modport master (
    output A, B, enable, clear_pos, clear_err,
    input  position, dir, step_pulse, speed, speed_valid, err
  );

  modport slave (
    input  A, B, enable, clear_pos, clear_err,
    output position, dir, step_pulse, speed, speed_valid, err
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: 2-flop sync, per-channel glitch filter, position/dir/err, windowed speed.
// Latency pin edge -> position/step_pulse is FILTER_CYCLES+3 clocks; no backpressure.
module quadrature_decoder #(
  parameter int CNT_WIDTH     = 16,
  parameter int FILTER_CYCLES = 4,
  parameter int SPEED_WINDOW  = 100000,
  parameter int SPD_WIDTH     = 16
) (
  input logic               clk,
  input logic               rst_n,
  quadrature_decoder_if.slave qif
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int WW = $clog2(SPEED_WINDOW);

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]          sync1, sync2, filt, prev;
  logic [1:0][FW-1:0]  fcnt;
  logic                fwd, rev, illegal, step_now;
  logic [CNT_WIDTH-1:0] pos_q;
  logic                dir_q, pulse_q, err_q, spd_vld_q;
  logic [WW-1:0]       win;
  logic [SPD_WIDTH-1:0] scnt, scnt_nxt, speed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      fcnt  <= '0;
    end else begin
      sync1 <= {qif.A, qif.B};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = 1'b0;
    case ({prev, filt})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
      default: ;
    endcase
  end

  assign step_now = qif.enable && (fwd || rev);
  // Step counter saturates; a step on the terminal window cycle still lands in that window.
  assign scnt_nxt = (step_now && scnt != '1) ? scnt + SPD_WIDTH'(1) : scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
      win       <= '0;
      scnt      <= '0;
      speed_q   <= '0;
      spd_vld_q <= 1'b0;
    end else begin
      prev    <= filt;
      pulse_q <= step_now;
      if (qif.clear_pos)
        pos_q <= '0;
      else if (step_now)
        pos_q <= fwd ? pos_q + CNT_WIDTH'(1) : pos_q - CNT_WIDTH'(1);
      if (step_now)
        dir_q <= rev;
      if (illegal)
        err_q <= 1'b1;
      else if (qif.clear_err)
        err_q <= 1'b0;
      if (win == WW'(SPEED_WINDOW - 1)) begin
        win       <= '0;
        speed_q   <= scnt_nxt;
        spd_vld_q <= 1'b1;
        scnt      <= '0;
      end else begin
        win       <= win + WW'(1);
        spd_vld_q <= 1'b0;
        scnt      <= scnt_nxt;
      end
    end
  end

  assign qif.position    = pos_q;
  assign qif.dir         = dir_q;
  assign qif.step_pulse  = pulse_q;
  assign qif.speed       = speed_q;
  assign qif.speed_valid = spd_vld_q;
  assign qif.err         = err_q;
endmodule
